// File: rtl/ebi_frame_engine.sv
// Half-duplex external bus frame engine: transmits and receives start/header/payload frames on a shared pad bus.
// Optional trailing XOR parity beat is enabled with `define EBI_PARITY_EN.
module ebi_frame_engine #(
  parameter int EBI_WIDTH = 16,
  parameter int MAX_BEATS = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter logic [EBI_WIDTH-1:0] START_PATTERN = {EBI_WIDTH{1'b1}},
  localparam int LEN_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           tx_valid_i,
  output logic                           tx_ready_o,
  input  logic [OPCODE_WIDTH-1:0]        tx_opcode_i,
  input  logic [LEN_WIDTH-1:0]           tx_len_i,
  input  logic [MAX_BEATS*EBI_WIDTH-1:0] tx_data_i,
  input  logic                           rx_en_i,
  output logic                           rx_valid_o,
  input  logic                           rx_ready_i,
  output logic [OPCODE_WIDTH-1:0]        rx_opcode_o,
  output logic [LEN_WIDTH-1:0]           rx_len_o,
  output logic [MAX_BEATS*EBI_WIDTH-1:0] rx_data_o,
  output logic                           rx_err_o,
  output logic                           rx_ovf_o,
  output logic                           busy_o,
  input  logic [EBI_WIDTH-1:0]           ebi_i,
  output logic [EBI_WIDTH-1:0]           ebi_o,
  output logic [EBI_WIDTH-1:0]           ebi_oen
);

`ifdef EBI_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BEATS);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_HDR, TX_DATA, TX_PAR, RX_HDR, RX_DATA, RX_PAR, RX_HOLD
  } state_t;

  state_t                         state_q, state_d;
  logic [LEN_WIDTH-1:0]           cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]           len_q, len_d;
  logic [EBI_WIDTH-1:0]           par_q, par_d;
  logic [OPCODE_WIDTH-1:0]        txOpc_q, txOpc_d;
  logic [MAX_BEATS*EBI_WIDTH-1:0] txBuf_q, txBuf_d;
  logic [EBI_WIDTH-1:0]           ebi_q, ebi_d;
  logic [EBI_WIDTH-1:0]           oen_q, oen_d;
  logic [OPCODE_WIDTH-1:0]        rxOpc_q, rxOpc_d;
  logic [LEN_WIDTH-1:0]           rxLen_q, rxLen_d;
  logic [MAX_BEATS*EBI_WIDTH-1:0] rxData_q, rxData_d;
  logic                           err_q, err_d;
  logic                           ovf_q, ovf_d;

  logic [EBI_WIDTH-1:0]           txHdr;
  logic [EBI_WIDTH-1:0]           txBeat;
  logic [LEN_WIDTH-1:0]           txLenClamp;
  logic [LEN_WIDTH-1:0]           rxLenRaw;
  logic                           startSeen;

  assign txLenClamp = (tx_len_i > MAX_LEN) ? MAX_LEN : tx_len_i;
  assign rxLenRaw   = ebi_i[OPCODE_WIDTH +: LEN_WIDTH];
  assign startSeen  = rx_en_i && (ebi_i == START_PATTERN);
  assign txBeat     = txBuf_q[int'(cnt_q)*EBI_WIDTH +: EBI_WIDTH];

  always_comb begin
    txHdr = '0;
    txHdr[OPCODE_WIDTH-1:0] = txOpc_q;
    txHdr[OPCODE_WIDTH +: LEN_WIDTH] = len_q;
  end

  // Pad outputs are computed for the upcoming state so they register alongside it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    par_d    = par_q;
    txOpc_d  = txOpc_q;
    txBuf_d  = txBuf_q;
    ebi_d    = '0;
    oen_d    = '1;
    rxOpc_d  = rxOpc_q;
    rxLen_d  = rxLen_q;
    rxData_d = rxData_q;
    err_d    = err_q;
    ovf_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          state_d = TX_START;
          txOpc_d = tx_opcode_i;
          len_d   = txLenClamp;
          txBuf_d = tx_data_i;
          ebi_d   = START_PATTERN;
          oen_d   = '0;
        end else if (startSeen) begin
          state_d = RX_HDR;
        end
      end
      TX_START: begin
        state_d = TX_HDR;
        ebi_d   = txHdr;
        oen_d   = '0;
        par_d   = txHdr;
        cnt_d   = '0;
      end
      TX_HDR, TX_DATA: begin
        if (cnt_q == len_q) begin
          state_d = PAR_EN ? TX_PAR : IDLE;
          if (PAR_EN) begin
            ebi_d = par_q;
            oen_d = '0;
          end
        end else begin
          state_d = TX_DATA;
          ebi_d   = txBeat;
          oen_d   = '0;
          par_d   = par_q ^ txBeat;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      TX_PAR: state_d = IDLE;
      RX_HDR: begin
        rxOpc_d  = ebi_i[OPCODE_WIDTH-1:0];
        len_d    = rxLenRaw;
        rxLen_d  = (rxLenRaw > MAX_LEN) ? MAX_LEN : rxLenRaw;
        err_d    = rxLenRaw > MAX_LEN;
        rxData_d = '0;
        par_d    = ebi_i;
        cnt_d    = '0;
        if (rxLenRaw == '0) state_d = PAR_EN ? RX_PAR : RX_HOLD;
        else state_d = RX_DATA;
      end
      RX_DATA: begin
        // Beats past MAX_BEATS are consumed for framing and parity but not stored.
        if (cnt_q < MAX_LEN) rxData_d[int'(cnt_q)*EBI_WIDTH +: EBI_WIDTH] = ebi_i;
        par_d = par_q ^ ebi_i;
        cnt_d = cnt_q + 1'b1;
        if ((cnt_q + 1'b1) == len_q) state_d = PAR_EN ? RX_PAR : RX_HOLD;
      end
      RX_PAR: begin
        if (ebi_i != par_q) err_d = 1'b1;
        state_d = RX_HOLD;
      end
      RX_HOLD: begin
        if (rx_ready_i) state_d = IDLE;
        if (startSeen) ovf_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      par_q    <= '0;
      txOpc_q  <= '0;
      txBuf_q  <= '0;
      ebi_q    <= '0;
      oen_q    <= '1;
      rxOpc_q  <= '0;
      rxLen_q  <= '0;
      rxData_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      par_q    <= par_d;
      txOpc_q  <= txOpc_d;
      txBuf_q  <= txBuf_d;
      ebi_q    <= ebi_d;
      oen_q    <= oen_d;
      rxOpc_q  <= rxOpc_d;
      rxLen_q  <= rxLen_d;
      rxData_q <= rxData_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rx_valid_o  = (state_q == RX_HOLD);
  assign rx_opcode_o = rxOpc_q;
  assign rx_len_o    = rxLen_q;
  assign rx_data_o   = rxData_q;
  assign rx_err_o    = err_q;
  assign rx_ovf_o    = ovf_q;
  assign ebi_o       = ebi_q;
  assign ebi_oen     = oen_q;

endmodule

// File: tb/tb_ebi_frame_engine.sv
// Directed bench for ebi_frame_engine: table-driven transmit/receive frames plus reset, overflow and priority sequences.
// Parity-specific sequences follow the EBI_PARITY_EN define used for the design.
module tb_ebi_frame_engine;
  localparam int W  = 16;
  localparam int MB = 32;
  localparam int OW = 4;
  localparam int LW = 6;
  localparam logic [W-1:0] START = 16'hFFFF;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            tx_valid_i = 1'b0;
  logic            tx_ready_o;
  logic [OW-1:0]   tx_opcode_i = '0;
  logic [LW-1:0]   tx_len_i = '0;
  logic [MB*W-1:0] tx_data_i = '0;
  logic            rx_en_i = 1'b0;
  logic            rx_valid_o;
  logic            rx_ready_i = 1'b0;
  logic [OW-1:0]   rx_opcode_o;
  logic [LW-1:0]   rx_len_o;
  logic [MB*W-1:0] rx_data_o;
  logic            rx_err_o;
  logic            rx_ovf_o;
  logic            busy_o;
  logic [W-1:0]    ebi_i = '0;
  logic [W-1:0]    ebi_o;
  logic [W-1:0]    ebi_oen;

  ebi_frame_engine dut (
    .clk(clk), .rstn(rstn),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_opcode_i(tx_opcode_i),
    .tx_len_i(tx_len_i), .tx_data_i(tx_data_i),
    .rx_en_i(rx_en_i), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_opcode_o(rx_opcode_o), .rx_len_o(rx_len_o), .rx_data_o(rx_data_o),
    .rx_err_o(rx_err_o), .rx_ovf_o(rx_ovf_o), .busy_o(busy_o),
    .ebi_i(ebi_i), .ebi_o(ebi_o), .ebi_oen(ebi_oen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] opc;
    logic [LW-1:0] len;
    logic [W-1:0]  b0, b1, b2;
    logic [W-1:0]  expHdr;
    int            expBeats;
  } txVec_t;

  typedef struct {
    logic [W-1:0]  hdr, b0, b1;
    int            nBeats;
    logic [OW-1:0] expOpc;
    logic [LW-1:0] expLen;
    logic          expErr;
    bit            dropEn;
  } rxVec_t;

  txVec_t txVecs[4];
  rxVec_t rxVecs[4];
  int checkCount = 0;
  int passCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic checkWide(input string name, input logic [MB*W-1:0] act, input logic [MB*W-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [W-1:0] ebiVal);
    ebi_i = ebiVal;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] txBeatOf(input txVec_t v, input int k);
    case (k)
      0: return v.b0;
      1: return v.b1;
      2: return v.b2;
      default: return 16'hC000 + W'(k);
    endcase
  endfunction

  function automatic logic [W-1:0] rxBeatOf(input rxVec_t v, input int k);
    case (k)
      0: return v.b0;
      1: return v.b1;
      default: return 16'h7700 + W'(k);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0]    par;
    logic [MB*W-1:0] expData;

    txVecs[0] = '{opc:4'h7, len:6'd2,  b0:16'h1234, b1:16'hBEEF, b2:16'h0000, expHdr:16'h0027, expBeats:2};
    txVecs[1] = '{opc:4'hA, len:6'd0,  b0:16'h5555, b1:16'h0000, b2:16'h0000, expHdr:16'h000A, expBeats:0};
    txVecs[2] = '{opc:4'h1, len:6'd3,  b0:16'h0001, b1:16'h8000, b2:16'h5A5A, expHdr:16'h0031, expBeats:3};
    txVecs[3] = '{opc:4'hF, len:6'd40, b0:16'h1357, b1:16'h2468, b2:16'h9ABC, expHdr:16'h020F, expBeats:32};

    rxVecs[0] = '{hdr:16'h0218, b0:16'hA0A0, b1:16'hB1B1, nBeats:33, expOpc:4'h8, expLen:6'd32, expErr:1'b1, dropEn:1'b0};
    rxVecs[1] = '{hdr:16'h0013, b0:16'h00AA, b1:16'h0000, nBeats:1,  expOpc:4'h3, expLen:6'd1,  expErr:1'b0, dropEn:1'b0};
    rxVecs[2] = '{hdr:16'h0029, b0:16'h1111, b1:16'h2222, nBeats:2,  expOpc:4'h9, expLen:6'd2,  expErr:1'b0, dropEn:1'b1};
    rxVecs[3] = '{hdr:16'h0005, b0:16'h0000, b1:16'h0000, nBeats:0,  expOpc:4'h5, expLen:6'd0,  expErr:1'b0, dropEn:1'b0};

    rstn = 1'b0;
    applyStimulus('0);
    applyStimulus('0);
    checkOutput("reset rx_valid", rx_valid_o, 1'b0);
    checkOutput("reset rx_err", rx_err_o, 1'b0);
    checkOutput("reset rx_ovf", rx_ovf_o, 1'b0);
    checkOutput("reset busy", busy_o, 1'b0);
    checkOutput("reset pads", {ebi_oen, ebi_o}, {16'hFFFF, 16'h0000});
    checkOutput("reset rx_opcode", rx_opcode_o, 4'h0);
    checkOutput("reset rx_len", rx_len_o, 6'd0);
    checkWide("reset rx_data", rx_data_o, '0);
    rstn = 1'b1;
    applyStimulus('0);
    checkOutput("tx_ready after reset", tx_ready_o, 1'b1);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < MB; k++) tx_data_i[k*W +: W] = txBeatOf(txVecs[i], k);
      tx_opcode_i = txVecs[i].opc;
      tx_len_i = txVecs[i].len;
      tx_valid_i = 1'b1;
      checkOutput($sformatf("tx%0d ready", i), tx_ready_o, 1'b1);
      applyStimulus('0);
      tx_valid_i = 1'b0;
      checkOutput($sformatf("tx%0d start", i), {ebi_oen, ebi_o}, {16'h0000, START});
      checkOutput($sformatf("tx%0d busy", i), busy_o, 1'b1);
      applyStimulus('0);
      checkOutput($sformatf("tx%0d hdr", i), {ebi_oen, ebi_o}, {16'h0000, txVecs[i].expHdr});
      par = txVecs[i].expHdr;
      for (int k = 0; k < txVecs[i].expBeats; k++) begin
        applyStimulus('0);
        checkOutput($sformatf("tx%0d beat%0d", i, k), {ebi_oen, ebi_o}, {16'h0000, txBeatOf(txVecs[i], k)});
        par = par ^ txBeatOf(txVecs[i], k);
      end
`ifdef EBI_PARITY_EN
      applyStimulus('0);
      checkOutput($sformatf("tx%0d parity", i), {ebi_oen, ebi_o}, {16'h0000, par});
`endif
      applyStimulus('0);
      checkOutput($sformatf("tx%0d end pads", i), {ebi_oen, ebi_o}, {16'hFFFF, 16'h0000});
      checkOutput($sformatf("tx%0d end ready", i), tx_ready_o, 1'b1);
    end

    for (int i = 0; i < 4; i++) begin
      rx_en_i = 1'b1;
      applyStimulus(START);
      checkOutput($sformatf("rx%0d busy", i), busy_o, 1'b1);
      if (rxVecs[i].dropEn) rx_en_i = 1'b0;
      applyStimulus(rxVecs[i].hdr);
      par = rxVecs[i].hdr;
      expData = '0;
      for (int k = 0; k < rxVecs[i].nBeats; k++) begin
        applyStimulus(rxBeatOf(rxVecs[i], k));
        par = par ^ rxBeatOf(rxVecs[i], k);
        if (k < MB) expData[k*W +: W] = rxBeatOf(rxVecs[i], k);
      end
`ifdef EBI_PARITY_EN
      applyStimulus(par);
`endif
      ebi_i = '0;
      checkOutput($sformatf("rx%0d valid", i), rx_valid_o, 1'b1);
      checkOutput($sformatf("rx%0d opcode", i), rx_opcode_o, rxVecs[i].expOpc);
      checkOutput($sformatf("rx%0d len", i), rx_len_o, rxVecs[i].expLen);
      checkOutput($sformatf("rx%0d err", i), rx_err_o, rxVecs[i].expErr);
      checkWide($sformatf("rx%0d data", i), rx_data_o, expData);
      rx_ready_i = 1'b1;
      applyStimulus('0);
      rx_ready_i = 1'b0;
      checkOutput($sformatf("rx%0d released", i), {rx_valid_o, busy_o}, 2'b00);
    end

    rx_en_i = 1'b1;
    applyStimulus(START);
    applyStimulus(16'h0013);
    applyStimulus(16'h00AA);
`ifdef EBI_PARITY_EN
    applyStimulus(16'h00B9);
`endif
    applyStimulus(16'h0000);
    checkOutput("ovf first valid", rx_valid_o, 1'b1);
    checkOutput("ovf no pulse yet", rx_ovf_o, 1'b0);
    applyStimulus(START);
    checkOutput("ovf pulse", rx_ovf_o, 1'b1);
    applyStimulus(16'h0022);
    checkOutput("ovf pulse once", rx_ovf_o, 1'b0);
    applyStimulus(16'h0055);
    checkOutput("ovf hold valid", rx_valid_o, 1'b1);
    checkOutput("ovf hold opcode", rx_opcode_o, 4'h3);
    checkOutput("ovf hold len", rx_len_o, 6'd1);
    checkWide("ovf hold data", rx_data_o, {{(MB-1)*W{1'b0}}, 16'h00AA});
    rx_ready_i = 1'b1;
    applyStimulus('0);
    rx_ready_i = 1'b0;
    checkOutput("ovf released", {rx_valid_o, busy_o}, 2'b00);

`ifdef EBI_PARITY_EN
    applyStimulus(START);
    applyStimulus(16'h0013);
    applyStimulus(16'h00AA);
    applyStimulus(16'h00B8);
    checkOutput("parity bad valid", rx_valid_o, 1'b1);
    checkOutput("parity bad err", rx_err_o, 1'b1);
    rx_ready_i = 1'b1;
    applyStimulus('0);
    rx_ready_i = 1'b0;
    applyStimulus(START);
    applyStimulus(16'h0013);
    applyStimulus(16'h00AA);
    applyStimulus(16'h00B9);
    checkOutput("parity good valid", rx_valid_o, 1'b1);
    checkOutput("parity good err", rx_err_o, 1'b0);
    rx_ready_i = 1'b1;
    applyStimulus('0);
    rx_ready_i = 1'b0;
`endif

    for (int k = 0; k < MB; k++) tx_data_i[k*W +: W] = 16'h3300 + W'(k);
    tx_opcode_i = 4'h1;
    tx_len_i = 6'd32;
    tx_valid_i = 1'b1;
    applyStimulus('0);
    tx_valid_i = 1'b0;
    applyStimulus('0);
    applyStimulus('0);
    applyStimulus('0);
    checkOutput("rst mid tx beat1", {ebi_oen, ebi_o}, {16'h0000, 16'h3301});
    rstn = 1'b0;
    applyStimulus('0);
    checkOutput("rst mid tx pads", {ebi_oen, ebi_o}, {16'hFFFF, 16'h0000});
    checkOutput("rst mid tx busy", busy_o, 1'b0);
    rstn = 1'b1;
    checkOutput("rst mid tx ready", tx_ready_o, 1'b1);
    applyStimulus('0);
    checkOutput("rst mid tx no resume", {ebi_oen, ebi_o, busy_o}, {16'hFFFF, 16'h0000, 1'b0});

    tx_data_i = '0;
    tx_data_i[W-1:0] = 16'h0F0F;
    tx_opcode_i = 4'h2;
    tx_len_i = 6'd1;
    tx_valid_i = 1'b1;
    rx_en_i = 1'b1;
    applyStimulus(START);
    tx_valid_i = 1'b0;
    checkOutput("prio start", {ebi_oen, ebi_o}, {16'h0000, START});
    applyStimulus(16'h0011);
    checkOutput("prio hdr", {ebi_oen, ebi_o}, {16'h0000, 16'h0012});
    applyStimulus(16'h00CC);
    checkOutput("prio beat", {ebi_oen, ebi_o}, {16'h0000, 16'h0F0F});
`ifdef EBI_PARITY_EN
    applyStimulus('0);
    checkOutput("prio parity", {ebi_oen, ebi_o}, {16'h0000, 16'h0F1D});
`endif
    applyStimulus('0);
    checkOutput("prio end pads", {ebi_oen, ebi_o}, {16'hFFFF, 16'h0000});
    checkOutput("prio no rx", {rx_valid_o, busy_o}, 2'b00);
    applyStimulus('0);
    checkOutput("prio still idle", {rx_valid_o, busy_o}, 2'b00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
